// File: rtl/bmr_tdee_led_pkg.sv
// Shared definitions for the LED PIO sequencer: mode encodings, arbiter states
// and the Avalon word layout of the LED data register.
package bmr_tdee_led_pkg;

    localparam int LED_W = 8;
    localparam int PIO_DATA_W = 32;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    typedef enum logic [1:0] {
        LED_MODE_STATIC = 2'd0,
        LED_MODE_BLINK  = 2'd1,
        LED_MODE_CHASE  = 2'd2,
        LED_MODE_BAR    = 2'd3
    } led_mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    // LED frame zero-extended into the 32-bit PIO data word
    function automatic logic [PIO_DATA_W-1:0] pio_word(input logic [LED_W-1:0] frame);
        return {{(PIO_DATA_W - LED_W){1'b0}}, frame};
    endfunction

endpackage

// File: rtl/bmr_tdee_led_sequencer_if.sv
// Host override handshake plus the Avalon-MM write-master signals towards the LED PIO.
interface bmr_tdee_led_sequencer_if;
    import bmr_tdee_led_pkg::*;

    logic                  host_req;
    logic [LED_W-1:0]      host_data;
    logic                  host_gnt;
    logic [1:0]            pio_address;
    logic                  pio_chipselect;
    logic                  pio_write_n;
    logic [PIO_DATA_W-1:0] pio_writedata;

    modport master (
        input  host_req,
        input  host_data,
        output host_gnt,
        output pio_address,
        output pio_chipselect,
        output pio_write_n,
        output pio_writedata
    );

    modport slave (
        output host_req,
        output host_data,
        input  host_gnt,
        input  pio_address,
        input  pio_chipselect,
        input  pio_write_n,
        input  pio_writedata
    );

endinterface

// File: rtl/bmr_tdee_led_frame_gen.sv
// Tick divider, step counter and pattern mux producing the sequencer's LED frame.
module bmr_tdee_led_frame_gen
    import bmr_tdee_led_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                advance_i,
    input  logic [1:0]          mode_i,
    input  logic [LED_W-1:0]    pattern_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic [LED_W-1:0]    frame_o
);

    logic [PERIOD_W-1:0] tick_q, tick_d;
    logic [3:0]          step_q, step_d;
    logic [3:0]          step_next;
    logic [1:0]          mode_q;
    logic [PERIOD_W-1:0] tick_last;
    logic [LED_W-1:0]    bar_mask;

    // A zero period behaves like one: advance every enabled cycle
    assign tick_last = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);

    // Bar runs a 9-step cycle (0..8); other modes only look at the low step bits
    always_comb begin
        step_next = step_q + 4'd1;
        if (led_mode_e'(mode_i) == LED_MODE_BAR && step_q >= 4'd8) begin
            step_next = 4'd0;
        end
    end

    always_comb begin
        tick_d = tick_q;
        step_d = step_q;
        if (mode_i != mode_q) begin
            tick_d = '0;
            step_d = 4'd0;
        end else if (advance_i) begin
            if (tick_q >= tick_last) begin
                tick_d = '0;
                step_d = step_next;
            end else begin
                tick_d = tick_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            step_q <= 4'd0;
        end else begin
            tick_q <= tick_d;
            step_q <= step_d;
        end
    end

    // Tracks mode even during reset so leaving reset is not seen as a mode change
    always_ff @(posedge clk) begin
        mode_q <= mode_i;
    end

    for (genvar gi = 0; gi < LED_W; gi++) begin : g_bar
        assign bar_mask[gi] = (step_q > 4'(gi));
    end

    always_comb begin
        frame_o = pattern_i;
        case (led_mode_e'(mode_i))
            LED_MODE_STATIC: frame_o = pattern_i;
            LED_MODE_BLINK:  frame_o = step_q[0] ? '0 : pattern_i;
            LED_MODE_CHASE:  frame_o = LED_W'(1) << step_q[2:0];
            LED_MODE_BAR:    frame_o = bar_mask;
            default:         frame_o = pattern_i;
        endcase
    end

endmodule

// File: rtl/bmr_tdee_led_sequencer.sv
// Sole Avalon-MM writer of the LED PIO: arbitrates host override writes against the
// internal pattern sequencer, with a hold-off window after each host write.
module bmr_tdee_led_sequencer
    import bmr_tdee_led_pkg::*;
#(
    parameter int PERIOD_W    = 24,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_i,
    input  logic [1:0]                mode_i,
    input  logic [LED_W-1:0]          pattern_i,
    input  logic [PERIOD_W-1:0]       period_i,
    bmr_tdee_led_sequencer_if.master  bus,
    output logic [LED_W-1:0]          led_shadow_o,
    output logic                      override_busy_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    arb_state_e            state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [LED_W-1:0]      frame;
    logic                  host_take;
    logic                  wr_d, gnt_d;
    logic [LED_W-1:0]      wr_data_d;
    logic                  cs_q, gnt_q;
    logic [PIO_DATA_W-1:0] wdata_q;
    logic [LED_W-1:0]      shadow_q;

    bmr_tdee_led_frame_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_frame_gen (
        .clk       (clk),
        .reset     (reset),
        .advance_i (enable_i && (state_q == ST_RUN)),
        .mode_i    (mode_i),
        .pattern_i (pattern_i),
        .period_i  (period_i),
        .frame_o   (frame)
    );

    // The request is still high while its grant is visible; ignore it for that one cycle
    assign host_take = bus.host_req && !gnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (host_take) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (host_take) begin
                    hold_cnt_d = HOLD_LOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Host always wins; the sequencer writes only on a real change of frame
    always_comb begin
        wr_d      = 1'b0;
        gnt_d     = 1'b0;
        wr_data_d = shadow_q;
        if (host_take) begin
            wr_d      = 1'b1;
            gnt_d     = 1'b1;
            wr_data_d = bus.host_data;
        end else if (state_q == ST_RUN && enable_i && frame != shadow_q) begin
            wr_d      = 1'b1;
            wr_data_d = frame;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q     <= 1'b0;
            gnt_q    <= 1'b0;
            wdata_q  <= '0;
            shadow_q <= '0;
        end else begin
            cs_q  <= wr_d;
            gnt_q <= gnt_d;
            if (wr_d) begin
                wdata_q  <= pio_word(wr_data_d);
                shadow_q <= wr_data_d;
            end
        end
    end

    assign bus.pio_address    = PIO_DATA_ADDR;
    assign bus.pio_chipselect = cs_q;
    assign bus.pio_write_n    = ~cs_q;
    assign bus.pio_writedata  = wdata_q;
    assign bus.host_gnt       = gnt_q;
    assign led_shadow_o       = shadow_q;
    assign override_busy_o    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_bmr_tdee_led_sequencer.sv
// Scoreboard bench: directed stimulus queues expected PIO writes and hold-off lengths,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_bmr_tdee_led_sequencer;
    import bmr_tdee_led_pkg::*;

    localparam int PERIOD_W = 24;
    localparam int HOLD     = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic [7:0]          pattern = 8'h00;
    logic [PERIOD_W-1:0] period = 24'd1;
    logic [7:0]          led_shadow;
    logic                override_busy;

    bmr_tdee_led_sequencer_if bus();

    bmr_tdee_led_sequencer #(
        .PERIOD_W    (PERIOD_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable_i        (enable),
        .mode_i          (mode),
        .pattern_i       (pattern),
        .period_i        (period),
        .bus             (bus),
        .led_shadow_o    (led_shadow),
        .override_busy_o (override_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       gnt;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   busy_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_wr = 0;
    int   busy_run = 0;
    logic rst_sampled = 1'b0;
    logic rst_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_sampled = reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_sampled) begin
            if (!rst_prev) begin
                chk("leftover_writes", 32'(exp_q.size()), 32'd0);
                chk("leftover_busy", 32'(busy_q.size()), 32'd0);
            end
            chk("rst_chipselect", 32'(bus.pio_chipselect), 32'd0);
            chk("rst_write_n", 32'(bus.pio_write_n), 32'd1);
            chk("rst_writedata", bus.pio_writedata, 32'd0);
            chk("rst_address", 32'(bus.pio_address), 32'd0);
            chk("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
            chk("rst_led_shadow", 32'(led_shadow), 32'd0);
            chk("rst_override_busy", 32'(override_busy), 32'd0);
            busy_run = 0;
        end else begin
            if (bus.pio_chipselect) begin
                $display("cycle %0d write data=0x%08h gnt=%0d shadow=0x%02h busy=%0d",
                         cyc, bus.pio_writedata, bus.host_gnt, led_shadow, override_busy);
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_write: got 0x%0h required no write", bus.pio_writedata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_data", bus.pio_writedata, {24'h0, mon_e.data});
                    chk("wr_host_gnt", 32'(bus.host_gnt), 32'(mon_e.gnt));
                    chk("wr_led_shadow", 32'(led_shadow), {24'h0, mon_e.data});
                    chk("wr_strobe_addr", {29'h0, bus.pio_write_n, bus.pio_address}, 32'd0);
                    if (mon_e.gap > 0) chk("wr_gap", 32'(cyc - last_wr), 32'(mon_e.gap));
                end
                last_wr = cyc;
            end else begin
                chk("idle_host_gnt", 32'(bus.host_gnt), 32'd0);
                chk("idle_write_n", 32'(bus.pio_write_n), 32'd1);
            end
            if (override_busy) begin
                busy_run = busy_run + 1;
            end else if (busy_run > 0) begin
                if (busy_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_busy: got %0d cycles required none", busy_run);
                end else begin
                    chk("busy_len", 32'(busy_run), 32'(busy_q.pop_front()));
                end
                busy_run = 0;
            end
        end
        if (reset) last_wr = cyc;
        rst_prev = rst_sampled;
    end

    // Enters reset, lets the monitor see it, then applies the next configuration
    task automatic begin_test(input logic [1:0] m, input logic [7:0] p, input int per);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        mode = m;
        pattern = p;
        period = PERIOD_W'(per);
        enable = 1'b1;
        bus.host_req = 1'b0;
        bus.host_data = 8'h00;
    endtask

    task automatic release_rst();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_w(input logic [7:0] d, input logic g, input int gap);
        exp_t e;
        e.data = d;
        e.gnt = g;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic host_write(input logic [7:0] d);
        bus.host_req = 1'b1;
        bus.host_data = d;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.host_req = 1'b0;
    endtask

    logic [7:0] chase_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    logic [7:0] bar_tab   [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};

    initial begin
        bus.host_req = 1'b0;
        bus.host_data = 8'h00;

        // static: one write of the pattern, nothing afterwards
        begin_test(2'd0, 8'hA5, 4);
        push_w(8'hA5, 1'b0, 2);
        release_rst();
        repeat (30) @(posedge clk);
        #1;

        // blink every 10 cycles
        begin_test(2'd1, 8'h3C, 10);
        push_w(8'h3C, 1'b0, 2);
        push_w(8'h00, 1'b0, 10);
        push_w(8'h3C, 1'b0, 10);
        push_w(8'h00, 1'b0, 10);
        release_rst();
        repeat (35) @(posedge clk);
        #1;

        // chase every cycle with 80->01 wrap, then freeze and resume from the frozen step
        begin_test(2'd2, 8'h00, 1);
        for (int i = 0; i < 10; i++) push_w(chase_tab[i], 1'b0, (i == 0) ? 2 : 1);
        release_rst();
        repeat (10) @(posedge clk);
        #1 enable = 1'b0;
        push_w(8'h04, 1'b0, 6);
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // bar every 2 cycles, 9-step cycle with FF->00 wrap
        begin_test(2'd3, 8'h00, 2);
        for (int i = 0; i < 10; i++) push_w(bar_tab[i], 1'b0, (i == 0) ? 4 : 2);
        release_rst();
        repeat (21) @(posedge clk);
        #1 enable = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // host write coincident with a chase step, hold-off, then resume
        begin_test(2'd2, 8'h00, 8);
        push_w(8'h01, 1'b0, 2);
        push_w(8'h5A, 1'b1, 8);
        push_w(8'h02, 1'b0, 17);
        push_w(8'h04, 1'b0, 7);
        busy_q.push_back(HOLD);
        release_rst();
        repeat (8) @(posedge clk);
        #1;
        host_write(8'h5A);
        repeat (27) @(posedge clk);
        #1;

        // second host write mid-hold reloads the hold count
        begin_test(2'd0, 8'h33, 4);
        push_w(8'h33, 1'b0, 2);
        push_w(8'h5A, 1'b1, 3);
        push_w(8'hC3, 1'b1, 9);
        push_w(8'h33, 1'b0, 17);
        busy_q.push_back(9 + HOLD);
        release_rst();
        repeat (3) @(posedge clk);
        #1;
        host_write(8'h5A);
        repeat (8) @(posedge clk);
        #1;
        host_write(8'hC3);
        repeat (25) @(posedge clk);
        #1;

        // reset in a write cycle, then reset in HOLD; the sequencer must write again afterwards
        begin_test(2'd0, 8'h81, 4);
        push_w(8'h81, 1'b0, 2);
        release_rst();
        @(posedge clk);
        #1;
        begin_test(2'd0, 8'h81, 4);
        push_w(8'h81, 1'b0, 2);
        push_w(8'h5A, 1'b1, 3);
        release_rst();
        repeat (3) @(posedge clk);
        #1;
        host_write(8'h5A);
        repeat (4) @(posedge clk);
        #1;
        begin_test(2'd0, 8'h81, 4);
        push_w(8'h81, 1'b0, 2);
        release_rst();
        repeat (6) @(posedge clk);
        #1;

        begin_test(2'd0, 8'h00, 1);
        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
